// File: rtl/led_pattern_gen_pkg.sv
// Shared encodings for the LED pattern generator: channel modes and the
// per-channel phase FSM states.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_ONESHOT = 2'd3
    } led_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ON_PH  = 2'd1,
        ST_OFF_PH = 2'd2
    } ch_state_t;

endpackage

// File: rtl/led_pattern_gen_if.sv
// Configuration write port of the LED pattern generator: a valid/ready
// handshake carrying target channel, mode and on/off durations.
interface led_pattern_gen_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [1:0]       cfg_mode;
    logic [CNT_W-1:0] cfg_on_time;
    logic [CNT_W-1:0] cfg_off_time;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_on_time, cfg_off_time,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_on_time, cfg_off_time,
        output cfg_ready
    );
endinterface

// File: rtl/led_pattern_gen_channel.sv
// One LED channel: holds its mode and durations, sequences ON/OFF phases on
// prescaler ticks and produces a registered LED bit and a completion strobe.
module led_channel
    import led_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load,
    input  led_mode_t        mode_in,
    input  logic [CNT_W-1:0] on_in,
    input  logic [CNT_W-1:0] off_in,
    output logic             led,
    output logic             pulse_done
);

    ch_state_t        state_q, state_d;
    led_mode_t        mode_q, mode_d;
    logic [CNT_W-1:0] on_q, off_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] dur;
    logic             fire_q, fire_d;

    // A load always wins over a phase ending in the same cycle, so a rewrite
    // exactly at ONESHOT completion suppresses the strobe.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        fire_d  = 1'b0;
        dur     = (state_q == ST_OFF_PH) ? off_q : on_q;
        if (load) begin
            mode_d  = mode_in;
            cnt_d   = '0;
            state_d = ST_IDLE;
            case (mode_in)
                MODE_BLINK: begin
                    if (on_in != '0) state_d = ST_ON_PH;
                end
                MODE_ONESHOT: begin
                    if (on_in != '0) begin
                        state_d = ST_ON_PH;
                    end else begin
                        mode_d = MODE_OFF;
                        fire_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (tick && (state_q != ST_IDLE)) begin
            if (cnt_q == dur - 1'b1) begin
                cnt_d = '0;
                if (mode_q == MODE_ONESHOT) begin
                    state_d = ST_IDLE;
                    mode_d  = MODE_OFF;
                    fire_d  = 1'b1;
                end else if ((state_q == ST_ON_PH) && (off_q != '0)) begin
                    state_d = ST_OFF_PH;
                end else begin
                    state_d = ST_ON_PH;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Outputs are one register stage behind the phase state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_OFF;
            on_q       <= '0;
            off_q      <= '0;
            cnt_q      <= '0;
            fire_q     <= 1'b0;
            led        <= 1'b0;
            pulse_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            fire_q     <= fire_d;
            if (load) begin
                on_q  <= on_in;
                off_q <= off_in;
            end
            led        <= (state_q == ST_ON_PH) ||
                          ((state_q == ST_IDLE) && (mode_q == MODE_ON));
            pulse_done <= fire_q;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared tick prescaler, config write
// decode and an array of independent pattern channels.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 32,
    parameter int PRESCALE = 1
) (
    input  logic              clk,
    input  logic              rst,
    led_pattern_gen_if.slave  cfg,
    output logic [NUM_CH-1:0] led,
    output logic [NUM_CH-1:0] pulse_done
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] ps_cnt;
    logic            tick;
    logic            ready_q;
    logic            accept;

    assign tick          = (ps_cnt == PS_W'(PRESCALE - 1));
    assign cfg.cfg_ready = ready_q;
    assign accept        = cfg.cfg_valid && ready_q;

    // Free-running time base; config writes deliberately do not realign it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_cnt <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Writes addressed beyond the last channel match no load strobe.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic load;
        assign load = accept && (32'(cfg.cfg_ch) == i);

        led_channel #(
            .CNT_W(CNT_W)
        ) u_channel (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .load      (load),
            .mode_in   (led_mode_t'(cfg.cfg_mode)),
            .on_in     (cfg.cfg_on_time),
            .off_in    (cfg.cfg_off_time),
            .led       (led[i]),
            .pulse_done(pulse_done[i])
        );
    end

endmodule
